ds18b20_slave_model: RTL and testbench

- Synthesizable 1-Wire responder that emulates a single DS18B20 on a shared DQ line.
- Its uses:
  - closed-loop bring-up of the team's DS18B20 master on the same FPGA;
  - board self-test without a physical sensor;
  - a stand-in sensor whose temperature comes from a fabric register.
- Answers the reset/presence sequence, accepts Skip ROM (0xCC), Convert T (0x44) and Read Scratchpad (0xBE), and returns a 9-byte scratchpad with valid Dallas CRC.

---
 rtl/ds18b20_slave_model_if.sv | 10 +
 rtl/ds18b20_slave_model.sv | 240 ++++++++++++++++++++++++
 tb/tb_ds18b20_slave_model.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ds18b20_slave_model_if.sv
`timescale 1ns/1ps
// DQ bus of the DS18B20 responder: the resolved bus level seen by the slave
// and the slave's open-drain pull-down request.
interface ds18b20_slave_model_if;
  logic dq_in;   // resolved DQ level (wired-AND of all drivers)
  logic dq_out;  // 0 = slave pulls DQ low, 1 = slave releases

  modport slave  (input dq_in, output dq_out);
  modport master (output dq_in, input dq_out);
endinterface

// File: rtl/ds18b20_slave_model.sv
`timescale 1ns/1ps
// ds18b20_slave_model: synthesizable single-device DS18B20 1-Wire responder.
// Handles reset/presence, Skip ROM, Convert T and Read Scratchpad, and
// returns a 9-byte scratchpad terminated by a Dallas CRC-8.
module ds18b20_slave_model #(
  parameter int unsigned CONV_US  = 750000,
  parameter logic [7:0]  TH_BYTE  = 8'h4B,
  parameter logic [7:0]  TL_BYTE  = 8'h46,
  parameter logic [7:0]  CFG_BYTE = 8'h7F
) (
  input  logic                        sysclk,
  input  logic                        rst,
  input  logic                        clk1mhz_en,
  ds18b20_slave_model_if.slave        bus,
  input  logic [15:0]                 temp_in,
  output logic                        conv_active,
  output logic [7:0]                  last_cmd,
  output logic                        reset_seen
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRES_DLY,
    S_PRES,
    S_ROM_RX,
    S_FN_RX,
    S_CONV_RD,
    S_TX
  } state_t;

  localparam logic [19:0] CONV_LOAD = 20'(CONV_US - 1);
  localparam logic [9:0]  RST_MIN   = 10'd480;

  state_t      r_state, w_next;
  logic        r_dq_m, r_dq_s, r_dq_d;
  logic        r_dq_out, w_dq_out_nxt;
  logic [9:0]  r_low_cnt;
  logic [7:0]  r_cnt;
  logic        r_in_slot;
  logic [6:0]  r_bit_cnt;
  logic [6:0]  r_shift;
  logic [7:0]  r_last_cmd;
  logic [7:0]  r_crc;
  logic        r_reset_seen;
  logic        r_conv_active;
  logic [19:0] r_conv_cnt;
  logic [15:0] r_temp, r_tx_temp;

  logic        w_fall, w_rise, w_reset_det;
  logic        w_rx_state, w_rd_state;
  logic        w_slot_start, w_slot_done, w_byte_done;
  logic [7:0]  w_rx_byte;
  logic        w_rd_bit;
  logic [63:0] w_sp;
  logic        w_crc_fb;
  logic [7:0]  w_crc_nxt;
  logic        w_conv_start;
  logic        w_state_chg, w_tx_entry;

  assign bus.dq_out  = r_dq_out;
  assign conv_active = r_conv_active;
  assign last_cmd    = r_last_cmd;
  assign reset_seen  = r_reset_seen;

  // Edges on the synchronized bus; falls caused by our own pull-down are masked.
  assign w_fall      = r_dq_d & ~r_dq_s & r_dq_out;
  assign w_rise      = ~r_dq_d & r_dq_s;
  assign w_reset_det = w_rise & (r_low_cnt >= RST_MIN);

  assign w_rx_state   = (r_state == S_ROM_RX) || (r_state == S_FN_RX);
  assign w_rd_state   = (r_state == S_CONV_RD) || (r_state == S_TX);
  assign w_slot_start = w_fall & ~r_in_slot & (w_rx_state | w_rd_state);
  assign w_slot_done  = r_in_slot & clk1mhz_en & (r_cnt == 8'd29);
  assign w_rx_byte    = {r_dq_s, r_shift};
  assign w_byte_done  = w_slot_done & w_rx_state & (r_bit_cnt == 7'd7);

  // Transmit image is taken from a snapshot so a conversion finishing
  // mid-read cannot corrupt the bytes or the CRC already in flight.
  assign w_sp = {8'h10, 8'h0C, 8'hFF, CFG_BYTE, TL_BYTE, TH_BYTE, r_tx_temp};

  // Bit offered in the current read slot.
  always_comb begin
    w_rd_bit = 1'b1;
    if (r_state == S_CONV_RD) begin
      w_rd_bit = ~r_conv_active;
    end else if (r_state == S_TX) begin
      if (r_bit_cnt < 7'd64) w_rd_bit = w_sp[r_bit_cnt[5:0]];
      else                   w_rd_bit = r_crc[r_bit_cnt[2:0]];
    end
  end

  assign w_crc_fb  = r_crc[0] ^ w_rd_bit;
  assign w_crc_nxt = {w_crc_fb, r_crc[7:5], r_crc[4] ^ w_crc_fb,
                      r_crc[3] ^ w_crc_fb, r_crc[2:1]};

  assign w_state_chg = (w_next != r_state) | w_reset_det;
  assign w_tx_entry  = (w_next == S_TX) && (r_state != S_TX);

  // Two-flop synchronizer on DQ plus a delayed copy for edge detection.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      {r_dq_m, r_dq_s, r_dq_d} <= '1;
    end else begin
      r_dq_m <= bus.dq_in;
      r_dq_s <= r_dq_m;
      r_dq_d <= r_dq_s;
    end
  end

  // Measure how long the master holds DQ low, for reset-pulse detection.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_low_cnt <= '0;
    end else if (r_dq_s) begin
      r_low_cnt <= '0;
    end else if (clk1mhz_en && r_dq_out && (r_low_cnt != '1)) begin
      r_low_cnt <= r_low_cnt + 10'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state, DQ drive request and conversion trigger.
  always_comb begin
    w_next       = r_state;
    w_dq_out_nxt = r_dq_out;
    w_conv_start = 1'b0;
    if (w_reset_det) begin
      w_next       = S_PRES_DLY;
      w_dq_out_nxt = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_PRES_DLY: begin
          if (clk1mhz_en && (r_cnt == 8'd29)) begin
            w_next       = S_PRES;
            w_dq_out_nxt = 1'b0;
          end
        end
        S_PRES: begin
          if (clk1mhz_en && (r_cnt == 8'd119)) begin
            w_next       = S_ROM_RX;
            w_dq_out_nxt = 1'b1;
          end
        end
        S_ROM_RX: begin
          if (w_byte_done) w_next = (w_rx_byte == 8'hCC) ? S_FN_RX : S_IDLE;
        end
        S_FN_RX: begin
          if (w_byte_done) begin
            if (w_rx_byte == 8'h44) begin
              w_next       = S_CONV_RD;
              w_conv_start = 1'b1;
            end else if (w_rx_byte == 8'hBE) begin
              w_next = S_TX;
            end else begin
              w_next = S_IDLE;
            end
          end
        end
        S_CONV_RD, S_TX: begin
          if (w_slot_start && !w_rd_bit) begin
            w_dq_out_nxt = 1'b0;
          end else if (w_slot_done) begin
            w_dq_out_nxt = 1'b1;
            if ((r_state == S_TX) && (r_bit_cnt == 7'd72)) w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Slot timing, bit counting, receive shifter, CRC and bus drive.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_dq_out     <= 1'b1;
      r_reset_seen <= 1'b0;
      r_cnt        <= '0;
      r_in_slot    <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_last_cmd   <= '0;
      r_crc        <= '0;
      r_tx_temp    <= '0;
    end else begin
      r_dq_out     <= w_dq_out_nxt;
      r_reset_seen <= w_reset_det;
      if (w_state_chg) begin
        r_cnt     <= '0;
        r_in_slot <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        if (w_slot_start) begin
          r_cnt     <= '0;
          r_in_slot <= 1'b1;
        end else if (w_slot_done) begin
          r_in_slot <= 1'b0;
        end else if (clk1mhz_en && (r_in_slot || (r_state == S_PRES_DLY) ||
                                    (r_state == S_PRES))) begin
          r_cnt <= r_cnt + 8'd1;
        end
        if ((w_slot_start && (r_state == S_TX)) || (w_slot_done && w_rx_state))
          r_bit_cnt <= r_bit_cnt + 7'd1;
      end
      if (w_slot_done && w_rx_state) r_shift <= w_rx_byte[7:1];
      if (w_byte_done) r_last_cmd <= w_rx_byte;
      if (w_tx_entry) begin
        r_crc     <= '0;
        r_tx_temp <= r_temp;
      end else if (w_slot_start && (r_state == S_TX) && (r_bit_cnt < 7'd64)) begin
        r_crc <= w_crc_nxt;
      end
    end
  end

  // Temperature conversion timer; survives bus resets, restarts on a new 0x44.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_conv_active <= 1'b0;
      r_conv_cnt    <= '0;
      r_temp        <= 16'h0550;
    end else if (w_conv_start) begin
      r_conv_active <= 1'b1;
      r_conv_cnt    <= CONV_LOAD;
    end else if (r_conv_active && clk1mhz_en) begin
      if (r_conv_cnt == '0) begin
        r_temp        <= temp_in;
        r_conv_active <= 1'b0;
      end else begin
        r_conv_cnt <= r_conv_cnt - 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_ds18b20_slave_model.sv
`timescale 1ns/1ps
// Directed bench for ds18b20_slave_model: a behavioural 1-Wire master drives
// DQ; one bus microsecond is one clk1mhz_en tick (every second sysclk).
module tb_ds18b20_slave_model;

  localparam int US = 20;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic        clk1mhz_en = 1'b0;
  logic        m_drive = 1'b1;
  logic [15:0] temp_in = 16'h0191;
  logic        conv_active;
  logic [7:0]  last_cmd;
  logic        reset_seen;
  int          n_pass = 0;
  int          n_checks = 0;
  int          rs_cnt = 0;

  ds18b20_slave_model_if u_if ();
  assign u_if.dq_in = m_drive & u_if.dq_out;

  ds18b20_slave_model #(.CONV_US(2000)) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .clk1mhz_en  (clk1mhz_en),
    .bus         (u_if),
    .temp_in     (temp_in),
    .conv_active (conv_active),
    .last_cmd    (last_cmd),
    .reset_seen  (reset_seen)
  );

  always #5 sysclk = ~sysclk;
  always @(negedge sysclk) clk1mhz_en <= ~clk1mhz_en;
  always @(posedge sysclk) if (reset_seen) rs_cnt <= rs_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] d);
    logic [7:0] c;
    logic [7:0] x;
    c = crc_in;
    x = d;
    for (int j = 0; j < 8; j++) begin
      if ((c[0] ^ x[0]) == 1'b1) c = (c >> 1) ^ 8'h8C;
      else                       c = c >> 1;
      x = x >> 1;
    end
    return c;
  endfunction

  task automatic write_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      m_drive = 1'b0;
      if (b[i]) begin #(6*US);  m_drive = 1'b1; #(58*US); end
      else      begin #(60*US); m_drive = 1'b1; #(4*US);  end
    end
  endtask

  task automatic read_bit(output logic b);
    m_drive = 1'b0;
    #(2*US);
    m_drive = 1'b1;
    #(11*US);
    b = u_if.dq_in;
    #(51*US);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic x;
    for (int i = 0; i < 8; i++) begin
      read_bit(x);
      b[i] = x;
    end
  endtask

  task automatic reset_pulse(output int first_low, output int n_low, output int rs_delta);
    int rs0;
    rs0 = rs_cnt;
    first_low = -1;
    n_low = 0;
    m_drive = 1'b0;
    #(600*US);
    m_drive = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      #(US);
      if (u_if.dq_out == 1'b0) begin
        n_low++;
        if (first_low < 0) first_low = k;
      end
    end
    rs_delta = rs_cnt - rs0;
  endtask

  task automatic test_reset;
    #(4*US);
    n_checks++; if (u_if.dq_out !== 1'b1) $display("FAIL rst_dq_out: got %b want 1", u_if.dq_out); else n_pass++;
    n_checks++; if (conv_active !== 1'b0) $display("FAIL rst_conv_active: got %b want 0", conv_active); else n_pass++;
    n_checks++; if (last_cmd !== 8'h00) $display("FAIL rst_last_cmd: got %h want 00", last_cmd); else n_pass++;
    rst = 1'b0;
    #(10*US);
    n_checks++; if (reset_seen !== 1'b0 || rs_cnt != 0) $display("FAIL rst_reset_seen: got %b/%0d want 0/0", reset_seen, rs_cnt); else n_pass++;
  endtask

  task automatic test_short_low;
    int rs0, lows;
    logic b;
    rs0 = rs_cnt;
    lows = 0;
    m_drive = 1'b0;
    #(300*US);
    m_drive = 1'b1;
    for (int k = 0; k < 200; k++) begin
      #(US);
      if (u_if.dq_out == 1'b0) lows++;
    end
    n_checks++; if (lows != 0) $display("FAIL short_no_presence: got %0d low us want 0", lows); else n_pass++;
    n_checks++; if (rs_cnt != rs0) $display("FAIL short_reset_seen: got %0d pulses want 0", rs_cnt - rs0); else n_pass++;
    read_bit(b);
    n_checks++; if (b !== 1'b1) $display("FAIL short_idle_slot: got %b want 1", b); else n_pass++;
  endtask

  task automatic test_presence;
    int fl, nl, rd;
    reset_pulse(fl, nl, rd);
    n_checks++; if (rd != 1) $display("FAIL pres_reset_seen: got %0d pulses want 1", rd); else n_pass++;
    n_checks++; if (fl < 29 || fl > 33) $display("FAIL pres_start: got %0d us want 29..33", fl); else n_pass++;
    n_checks++; if (nl < 118 || nl > 122) $display("FAIL pres_width: got %0d us want 118..122", nl); else n_pass++;
    n_checks++; if (u_if.dq_out !== 1'b1) $display("FAIL pres_release: got %b want 1", u_if.dq_out); else n_pass++;
  endtask

  task automatic test_conversion;
    int fl, nl, rd;
    logic b;
    reset_pulse(fl, nl, rd);
    write_byte(8'hCC);
    write_byte(8'h44);
    // conversion began about 32 us before this point and lasts 2000 us
    n_checks++; if (last_cmd !== 8'h44) $display("FAIL conv_last_cmd: got %h want 44", last_cmd); else n_pass++;
    n_checks++; if (conv_active !== 1'b1) $display("FAIL conv_active_start: got %b want 1", conv_active); else n_pass++;
    read_bit(b);
    n_checks++; if (b !== 1'b0) $display("FAIL conv_busy_slot0: got %b want 0", b); else n_pass++;
    #((1880-64)*US);
    read_bit(b);
    n_checks++; if (b !== 1'b0) $display("FAIL conv_busy_late: got %b want 0", b); else n_pass++;
    #(6*US);
    n_checks++; if (conv_active !== 1'b1) $display("FAIL conv_active_1950: got %b want 1", conv_active); else n_pass++;
    #(35*US);
    n_checks++; if (conv_active !== 1'b0) $display("FAIL conv_active_1985: got %b want 0", conv_active); else n_pass++;
    read_bit(b);
    n_checks++; if (b !== 1'b1) $display("FAIL conv_done_slot: got %b want 1", b); else n_pass++;
    temp_in = 16'hABCD;
  endtask

  task automatic test_scratchpad;
    int fl, nl, rd;
    logic [7:0] exp_b [9];
    logic [7:0] got;
    logic [7:0] crc;
    logic b;
    exp_b = '{8'h91, 8'h01, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h00};
    crc = 8'h00;
    for (int i = 0; i < 8; i++) crc = crc8_byte(crc, exp_b[i]);
    exp_b[8] = crc;
    reset_pulse(fl, nl, rd);
    write_byte(8'hCC);
    write_byte(8'hBE);
    n_checks++; if (last_cmd !== 8'hBE) $display("FAIL sp_last_cmd: got %h want BE", last_cmd); else n_pass++;
    crc = 8'h00;
    for (int i = 0; i < 9; i++) begin
      read_byte(got);
      crc = crc8_byte(crc, got);
      n_checks++; if (got !== exp_b[i]) $display("FAIL sp_byte%0d: got %h want %h", i, got, exp_b[i]); else n_pass++;
    end
    n_checks++; if (crc !== 8'h00) $display("FAIL sp_crc_residue: got %h want 00", crc); else n_pass++;
    read_bit(b);
    n_checks++; if (b !== 1'b1) $display("FAIL sp_slot73: got %b want 1", b); else n_pass++;
  endtask

  task automatic test_bad_cmd;
    int fl, nl, rd;
    logic b;
    reset_pulse(fl, nl, rd);
    write_byte(8'h33);
    n_checks++; if (last_cmd !== 8'h33) $display("FAIL bad_last_cmd: got %h want 33", last_cmd); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      read_bit(b);
      n_checks++; if (b !== 1'b1) $display("FAIL bad_idle_slot%0d: got %b want 1", i, b); else n_pass++;
    end
  endtask

  task automatic test_abort;
    int fl, nl, rd;
    logic [7:0] exp_b [9];
    logic [7:0] got;
    logic [7:0] crc;
    logic b;
    exp_b = '{8'h91, 8'h01, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h00};
    crc = 8'h00;
    for (int i = 0; i < 8; i++) crc = crc8_byte(crc, exp_b[i]);
    exp_b[8] = crc;
    reset_pulse(fl, nl, rd);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(got);
    n_checks++; if (got !== 8'h91) $display("FAIL abort_pre_byte0: got %h want 91", got); else n_pass++;
    read_byte(got);
    n_checks++; if (got !== 8'h01) $display("FAIL abort_pre_byte1: got %h want 01", got); else n_pass++;
    for (int i = 0; i < 4; i++) read_bit(b);
    reset_pulse(fl, nl, rd);
    n_checks++; if (rd != 1) $display("FAIL abort_reset_seen: got %0d pulses want 1", rd); else n_pass++;
    n_checks++; if (nl < 118 || nl > 122) $display("FAIL abort_presence: got %0d us want 118..122", nl); else n_pass++;
    write_byte(8'hCC);
    write_byte(8'hBE);
    crc = 8'h00;
    for (int i = 0; i < 9; i++) begin
      read_byte(got);
      crc = crc8_byte(crc, got);
      n_checks++; if (got !== exp_b[i]) $display("FAIL abort_byte%0d: got %h want %h", i, got, exp_b[i]); else n_pass++;
    end
    n_checks++; if (crc !== 8'h00) $display("FAIL abort_crc_residue: got %h want 00", crc); else n_pass++;
    // async reset in the middle of a presence pulse
    m_drive = 1'b0;
    #(600*US);
    m_drive = 1'b1;
    #(60*US);
    n_checks++; if (u_if.dq_out !== 1'b0) $display("FAIL midpres_driving: got %b want 0", u_if.dq_out); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (u_if.dq_out !== 1'b1) $display("FAIL midpres_rst_release: got %b want 1", u_if.dq_out); else n_pass++;
    #(US-1);
    #(2*US);
    rst = 1'b0;
    #(10*US);
  endtask

  initial begin
    #3;
    test_reset;
    test_short_low;
    test_presence;
    test_conversion;
    test_scratchpad;
    test_bad_cmd;
    test_abort;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
